// File: rtl/rob_multi.sv
// Reorder buffer: in-order allocate, out-of-order complete, in-order commit of up to COMMIT_W entries per cycle.
// Latency: writeback in cycle N is committed in cycle N+1 at the earliest; lookups and commit outputs are combinational.
// Backpressure: alloc_ready_o drops when all DEPTH entries are occupied; a commit in the same cycle does not free a slot until the next cycle.
//
// Ports:
//   clk_i, rstn_i                      clock, asynchronous active-low reset
//   alloc_*                            decode allocation at tail; alloc_idx_o is the tail index handed out
//   wb_*                               writeback completion of entry wb_idx_i (result, branch outcome)
//   commit_*                           per-lane retire bundle, lane 0 oldest; flush_o/flush_pc_o redirect fetch
//   count_o                            occupied entries
//   rs_addr_i, hazard_o, hazard_idx_o,
//   completed_o, result_o              two RAW lookup ports; slot 0 is rs1, slot 1 is rs2
//
// Optional feature: define ROB_WB_BYPASS_EN to forward the writeback bus into the lookup ports in the same cycle.
module rob_multi #(
  parameter int DEPTH    = 8,
  parameter int COMMIT_W = 2,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   alloc_valid_i,
  input  logic [31:0]            alloc_pc_i,
  input  logic [31:0]            alloc_instr_i,
  input  logic [4:0]             alloc_rd_i,
  input  logic                   alloc_we_i,
  output logic                   alloc_ready_o,
  output logic [IDX_W-1:0]       alloc_idx_o,
  input  logic                   wb_valid_i,
  input  logic [IDX_W-1:0]       wb_idx_i,
  input  logic [31:0]            wb_result_i,
  input  logic                   wb_branch_taken_i,
  input  logic [31:0]            wb_new_pc_i,
  output logic [COMMIT_W-1:0]    commit_valid_o,
  output logic [COMMIT_W*32-1:0] commit_pc_o,
  output logic [COMMIT_W*32-1:0] commit_instr_o,
  output logic [COMMIT_W*5-1:0]  commit_rd_o,
  output logic [COMMIT_W*32-1:0] commit_result_o,
  output logic [COMMIT_W-1:0]    commit_we_o,
  output logic                   flush_o,
  output logic [31:0]            flush_pc_o,
  output logic [IDX_W:0]         count_o,
  input  logic [9:0]             rs_addr_i,
  output logic [1:0]             hazard_o,
  output logic [2*IDX_W-1:0]     hazard_idx_o,
  output logic [1:0]             completed_o,
  output logic [63:0]            result_o
);

  localparam int CNT_W = IDX_W + 1;

  // Fields written at allocation time.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
  } alloc_ent_t;

  // Fields written at writeback time.
  typedef struct packed {
    logic [31:0] result;
    logic        branch_taken;
    logic [31:0] new_pc;
  } wb_ent_t;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  alloc_ent_t       ent_a_q [DEPTH];
  wb_ent_t          ent_w_q [DEPTH];
  logic [IDX_W-1:0] head_q;
  logic [IDX_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  logic [COMMIT_W-1:0] lane_vld;
  logic [CNT_W-1:0]    n_commit;
  logic                flush;
  logic [31:0]         flush_pc;
  logic                alloc_fire;
  logic                wb_fire;
  logic [IDX_W-1:0]    head_nxt;

  // ---------------------------------------------------------------------------
  // Commit: walk lanes from the head; a lane may retire only if every older
  // lane retires and none of them is a taken branch (younger work is squashed).
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             older_ok;
    lane_vld        = '0;
    n_commit        = '0;
    flush           = 1'b0;
    flush_pc        = '0;
    commit_pc_o     = '0;
    commit_instr_o  = '0;
    commit_rd_o     = '0;
    commit_result_o = '0;
    commit_we_o     = '0;
    idx             = head_q;
    older_ok        = 1'b1;
    for (int l = 0; l < COMMIT_W; l++) begin
      idx = head_q + IDX_W'(l);
      if (older_ok && valid_q[idx] && done_q[idx]) begin
        lane_vld[l]                = 1'b1;
        n_commit                   = n_commit + CNT_W'(1);
        commit_pc_o[l*32 +: 32]     = ent_a_q[idx].pc;
        commit_instr_o[l*32 +: 32]  = ent_a_q[idx].instr;
        commit_rd_o[l*5 +: 5]       = ent_a_q[idx].rd;
        commit_result_o[l*32 +: 32] = ent_w_q[idx].result;
        commit_we_o[l]             = ent_a_q[idx].we && (ent_a_q[idx].rd != 5'd0);
        if (ent_w_q[idx].branch_taken) begin
          flush    = 1'b1;
          flush_pc = ent_w_q[idx].new_pc;
        end
        older_ok = !ent_w_q[idx].branch_taken;
      end else begin
        older_ok = 1'b0;
      end
    end
  end

  assign commit_valid_o = lane_vld;
  assign flush_o        = flush;
  assign flush_pc_o     = flush_pc;
  assign count_o        = count_q;
  assign alloc_idx_o    = tail_q;

  // Readiness looks only at the registered count so a slot freed by this
  // cycle's commit is never handed out in the same cycle.
  assign alloc_ready_o = (count_q < CNT_W'(DEPTH));
  assign alloc_fire    = alloc_valid_i && alloc_ready_o && !flush;
  assign wb_fire       = wb_valid_i && valid_q[wb_idx_i] && !flush;
  assign head_nxt      = head_q + n_commit[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_nxt;
      if (flush) begin
        // The branch and anything older retire; everything younger vanishes.
        valid_q <= '0;
        done_q  <= '0;
        tail_q  <= head_nxt;
        count_q <= '0;
      end else begin
        // Writeback first so a retiring entry still ends up cleared below.
        if (wb_fire) begin
          done_q[wb_idx_i] <= 1'b1;
        end
        for (int l = 0; l < COMMIT_W; l++) begin
          if (lane_vld[l]) begin
            valid_q[head_q + IDX_W'(l)] <= 1'b0;
            done_q[head_q + IDX_W'(l)]  <= 1'b0;
          end
        end
        if (alloc_fire) begin
          valid_q[tail_q] <= 1'b1;
          done_q[tail_q]  <= 1'b0;
          tail_q          <= tail_q + IDX_W'(1);
        end
        count_q <= count_q + CNT_W'(alloc_fire) - n_commit;
      end
    end
  end

  // Payload needs no reset: it is only observed through valid/done-qualified paths.
  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      ent_a_q[tail_q] <= '{pc: alloc_pc_i, instr: alloc_instr_i, rd: alloc_rd_i, we: alloc_we_i};
    end
    if (wb_fire) begin
      ent_w_q[wb_idx_i] <= '{result: wb_result_i, branch_taken: wb_branch_taken_i,
                             new_pc: wb_new_pc_i};
    end
  end

  // ---------------------------------------------------------------------------
  // Operand lookup: scan oldest to youngest from the head so the last hit is
  // the youngest producer. Entries retiring this cycle still match.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [4:0]       addr;
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             hit_done;
    logic [31:0]      hit_res;
    hazard_o     = '0;
    hazard_idx_o = '0;
    completed_o  = '0;
    result_o     = '0;
    addr         = '0;
    idx          = '0;
    for (int s = 0; s < 2; s++) begin
      addr     = rs_addr_i[s*5 +: 5];
      hit      = 1'b0;
      hit_idx  = '0;
      hit_done = 1'b0;
      hit_res  = '0;
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + IDX_W'(i);
        if (valid_q[idx] && ent_a_q[idx].we && (ent_a_q[idx].rd == addr) && (addr != 5'd0)) begin
          hit      = 1'b1;
          hit_idx  = idx;
          hit_done = done_q[idx];
          hit_res  = done_q[idx] ? ent_w_q[idx].result : 32'd0;
        end
      end
`ifdef ROB_WB_BYPASS_EN
      // Producer completing right now: hand its result to decode immediately.
      if (hit && wb_valid_i && (wb_idx_i == hit_idx)) begin
        hit_done = 1'b1;
        hit_res  = wb_result_i;
      end
`else
`endif
      hazard_o[s]                   = hit;
      hazard_idx_o[s*IDX_W +: IDX_W] = hit_idx;
      completed_o[s]                = hit_done;
      result_o[s*32 +: 32]           = hit_res;
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// Bench for rob_multi (DEPTH=8, COMMIT_W=2): directed table, hand sequences, randomized run vs. queue model.
module tb_rob_multi;
  localparam int DEPTH    = 8;
  localparam int COMMIT_W = 2;
  localparam int IDX_W    = 3;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        alloc_valid_i;
  logic [31:0] alloc_pc_i;
  logic [31:0] alloc_instr_i;
  logic [4:0]  alloc_rd_i;
  logic        alloc_we_i;
  logic        alloc_ready_o;
  logic [2:0]  alloc_idx_o;
  logic        wb_valid_i;
  logic [2:0]  wb_idx_i;
  logic [31:0] wb_result_i;
  logic        wb_branch_taken_i;
  logic [31:0] wb_new_pc_i;
  logic [1:0]  commit_valid_o;
  logic [63:0] commit_pc_o;
  logic [63:0] commit_instr_o;
  logic [9:0]  commit_rd_o;
  logic [63:0] commit_result_o;
  logic [1:0]  commit_we_o;
  logic        flush_o;
  logic [31:0] flush_pc_o;
  logic [3:0]  count_o;
  logic [9:0]  rs_addr_i;
  logic [1:0]  hazard_o;
  logic [5:0]  hazard_idx_o;
  logic [1:0]  completed_o;
  logic [63:0] result_o;

  rob_multi #(.DEPTH(DEPTH), .COMMIT_W(COMMIT_W), .IDX_W(IDX_W)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .alloc_valid_i(alloc_valid_i), .alloc_pc_i(alloc_pc_i), .alloc_instr_i(alloc_instr_i),
    .alloc_rd_i(alloc_rd_i), .alloc_we_i(alloc_we_i),
    .alloc_ready_o(alloc_ready_o), .alloc_idx_o(alloc_idx_o),
    .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_result_i(wb_result_i),
    .wb_branch_taken_i(wb_branch_taken_i), .wb_new_pc_i(wb_new_pc_i),
    .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o), .commit_instr_o(commit_instr_o),
    .commit_rd_o(commit_rd_o), .commit_result_o(commit_result_o), .commit_we_o(commit_we_o),
    .flush_o(flush_o), .flush_pc_o(flush_pc_o), .count_o(count_o),
    .rs_addr_i(rs_addr_i), .hazard_o(hazard_o), .hazard_idx_o(hazard_idx_o),
    .completed_o(completed_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    alloc_valid_i = 1'b0; alloc_pc_i = '0; alloc_instr_i = '0; alloc_rd_i = '0; alloc_we_i = 1'b0;
    wb_valid_i = 1'b0; wb_idx_i = '0; wb_result_i = '0; wb_branch_taken_i = 1'b0; wb_new_pc_i = '0;
    rs_addr_i = '0;
  endtask

  // Inputs change on the falling edge; checks happen 1 time unit later.
  task automatic cyc();
    @(negedge clk_i);
    clr();
  endtask

  task automatic do_alloc(input logic [31:0] pc, input logic [4:0] rd, input logic we);
    cyc();
    alloc_valid_i = 1'b1; alloc_pc_i = pc; alloc_instr_i = ~pc; alloc_rd_i = rd; alloc_we_i = we;
  endtask

  task automatic do_wb(input logic [2:0] idx, input logic [31:0] res, input logic bt, input logic [31:0] npc);
    cyc();
    wb_valid_i = 1'b1; wb_idx_i = idx; wb_result_i = res; wb_branch_taken_i = bt; wb_new_pc_i = npc;
  endtask

  task automatic do_reset();
    cyc();
    rstn_i = 1'b0;
    #2;
    rstn_i = 1'b1;
  endtask

  typedef struct {
    logic        av;
    logic        wv;
    logic [2:0]  wi;
    logic        er;
    logic [2:0]  ei;
    logic [3:0]  ec;
    logic [1:0]  ecv;
    logic [31:0] epc;
    logic [31:0] eres;
  } vec_t;

  vec_t tbl [13];

  // Reference model entry: one per in-flight instruction, kept in age order.
  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        we;
    logic        done;
    logic [31:0] result;
    logic        bt;
    logic [31:0] npc;
  } ment_t;

  ment_t mq[$];
  int    m_head;
  int    m_tail;
  int    pend[$];

  logic exp_byp;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int    ncm;
    logic  fl;
    logic [31:0] fpc;
    int    presize;
    int    found;
    logic [4:0] a;
    logic  ecomp;
    logic [31:0] eres;
    ment_t e;

`ifdef ROB_WB_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif

    // Full/wrap table: fill 8 entries, refuse the 9th, commit idx0, refuse on the commit cycle, wrap to idx0.
    for (int r = 0; r < 13; r++) begin
      tbl[r] = '{av: 1'b1, wv: 1'b0, wi: 3'd0, er: 1'b1, ei: 3'(r), ec: 4'(r), ecv: 2'b00,
                 epc: 32'd0, eres: 32'd0};
    end
    tbl[8]  = '{av: 1'b1, wv: 1'b0, wi: 3'd0, er: 1'b0, ei: 3'd0, ec: 4'd8, ecv: 2'b00, epc: 32'd0, eres: 32'd0};
    tbl[9]  = '{av: 1'b0, wv: 1'b1, wi: 3'd0, er: 1'b0, ei: 3'd0, ec: 4'd8, ecv: 2'b00, epc: 32'd0, eres: 32'd0};
    tbl[10] = '{av: 1'b1, wv: 1'b0, wi: 3'd0, er: 1'b0, ei: 3'd0, ec: 4'd8, ecv: 2'b01,
                epc: 32'h1000, eres: 32'hA9};
    tbl[11] = '{av: 1'b1, wv: 1'b0, wi: 3'd0, er: 1'b1, ei: 3'd0, ec: 4'd7, ecv: 2'b00, epc: 32'd0, eres: 32'd0};
    tbl[12] = '{av: 1'b0, wv: 1'b0, wi: 3'd0, er: 1'b0, ei: 3'd1, ec: 4'd8, ecv: 2'b00, epc: 32'd0, eres: 32'd0};

    // ---------------- reset state ----------------
    clr();
    rstn_i = 1'b0;
    rs_addr_i = {5'd3, 5'd1};
    #1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_ready", 64'(alloc_ready_o), 64'd1);
    chk("rst_idx", 64'(alloc_idx_o), 64'd0);
    chk("rst_cv", 64'(commit_valid_o), 64'd0);
    chk("rst_cwe", 64'(commit_we_o), 64'd0);
    chk("rst_flush", {flush_o, flush_pc_o}, 64'd0);
    chk("rst_hazard", 64'(hazard_o), 64'd0);
    chk("rst_completed", 64'(completed_o), 64'd0);
    @(negedge clk_i);
    #2;
    rstn_i = 1'b1;

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 5; i++) do_alloc(32'h100 + 32'(4 * i), 5'(i + 1), 1'b1);
    cyc(); #1;
    chk("mid_count_pre", 64'(count_o), 64'd5);
    rstn_i = 1'b0;
    #1;
    chk("mid_count", 64'(count_o), 64'd0);
    chk("mid_ready", 64'(alloc_ready_o), 64'd1);
    chk("mid_idx", 64'(alloc_idx_o), 64'd0);
    chk("mid_cv", 64'(commit_valid_o), 64'd0);
    #1;
    rstn_i = 1'b1;
    do_wb(3'd2, 32'h55, 1'b0, 32'd0); #1;
    chk("mid_wb_cv", 64'(commit_valid_o), 64'd0);
    for (int i = 0; i < 3; i++) do_alloc(32'h140 + 32'(4 * i), 5'(i + 1), 1'b1);
    do_wb(3'd1, 32'h61, 1'b0, 32'd0);
    do_wb(3'd0, 32'h60, 1'b0, 32'd0);
    cyc(); #1;
    chk("mid_pair_cv", 64'(commit_valid_o), 64'b11);
    chk("mid_pair_count", 64'(count_o), 64'd3);
    cyc(); #1;
    chk("mid_stale_wb_ignored", 64'(commit_valid_o), 64'd0);
    chk("mid_count_left", 64'(count_o), 64'd1);

    // ---------------- table: full, refuse, wrap ----------------
    do_reset();
    for (int r = 0; r < 13; r++) begin
      cyc();
      alloc_valid_i = tbl[r].av;
      alloc_pc_i    = 32'h1000 + 32'(4 * r);
      alloc_instr_i = 32'hC000 + 32'(r);
      alloc_rd_i    = 5'(r + 1);
      alloc_we_i    = 1'b1;
      wb_valid_i    = tbl[r].wv;
      wb_idx_i      = tbl[r].wi;
      wb_result_i   = 32'hA0 + 32'(r);
      #1;
      chk($sformatf("tbl%0d_ready", r), 64'(alloc_ready_o), 64'(tbl[r].er));
      chk($sformatf("tbl%0d_idx", r), 64'(alloc_idx_o), 64'(tbl[r].ei));
      chk($sformatf("tbl%0d_count", r), 64'(count_o), 64'(tbl[r].ec));
      chk($sformatf("tbl%0d_cv", r), 64'(commit_valid_o), 64'(tbl[r].ecv));
      if (tbl[r].ecv[0]) begin
        chk($sformatf("tbl%0d_pc", r), 64'(commit_pc_o[31:0]), 64'(tbl[r].epc));
        chk($sformatf("tbl%0d_res", r), 64'(commit_result_o[31:0]), 64'(tbl[r].eres));
      end
    end

    // ---------------- out-of-order completion, paired commit ----------------
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc(32'h200 + 32'(4 * i), 5'(i + 1), 1'b1);
    do_wb(3'd3, 32'h33, 1'b0, 32'd0); #1;
    chk("ord_cv_w3", 64'(commit_valid_o), 64'd0);
    do_wb(3'd1, 32'h31, 1'b0, 32'd0); #1;
    chk("ord_cv_w1", 64'(commit_valid_o), 64'd0);
    do_wb(3'd0, 32'h30, 1'b0, 32'd0); #1;
    chk("ord_cv_w0", 64'(commit_valid_o), 64'd0);
    do_wb(3'd2, 32'h32, 1'b0, 32'd0); #1;
    chk("ord_pair01_cv", 64'(commit_valid_o), 64'b11);
    chk("ord_pair01_count", 64'(count_o), 64'd4);
    chk("ord_pair01_pc", commit_pc_o, {32'h204, 32'h200});
    chk("ord_pair01_res", commit_result_o, {32'h31, 32'h30});
    chk("ord_pair01_we", 64'(commit_we_o), 64'b11);
    cyc(); #1;
    chk("ord_pair23_cv", 64'(commit_valid_o), 64'b11);
    chk("ord_pair23_count", 64'(count_o), 64'd2);
    chk("ord_pair23_pc", commit_pc_o, {32'h20C, 32'h208});
    cyc(); #1;
    chk("ord_empty_count", 64'(count_o), 64'd0);
    chk("ord_empty_cv", 64'(commit_valid_o), 64'd0);

    // ---------------- taken branch flush ----------------
    do_reset();
    for (int i = 0; i < 4; i++) do_alloc(32'h300 + 32'(4 * i), 5'(i + 1), 1'b1);
    do_wb(3'd2, 32'h42, 1'b0, 32'd0);
    do_wb(3'd3, 32'h43, 1'b0, 32'd0);
    do_wb(3'd0, 32'h40, 1'b0, 32'd0);
    do_wb(3'd1, 32'h41, 1'b1, 32'h80); #1;
    chk("br_pre_cv", 64'(commit_valid_o), 64'b01);
    chk("br_pre_flush", 64'(flush_o), 64'd0);
    cyc();
    alloc_valid_i = 1'b1; alloc_pc_i = 32'hBAD; alloc_rd_i = 5'd1; alloc_we_i = 1'b1;
    #1;
    chk("br_cv", 64'(commit_valid_o), 64'b01);
    chk("br_flush", 64'(flush_o), 64'd1);
    chk("br_flush_pc", 64'(flush_pc_o), 64'h80);
    chk("br_pc", 64'(commit_pc_o[31:0]), 64'h304);
    chk("br_count", 64'(count_o), 64'd3);
    cyc(); #1;
    chk("br_after_count", 64'(count_o), 64'd0);
    chk("br_after_flush", 64'(flush_o), 64'd0);
    chk("br_after_cv", 64'(commit_valid_o), 64'd0);
    chk("br_after_idx", 64'(alloc_idx_o), 64'd2);
    cyc(); #1;
    chk("br_squashed_cv", 64'(commit_valid_o), 64'd0);

    // ---------------- RAW lookup, youngest producer ----------------
    do_reset();
    do_alloc(32'h400, 5'd5, 1'b1);
    do_alloc(32'h404, 5'd7, 1'b1);
    do_alloc(32'h408, 5'd5, 1'b1);
    do_wb(3'd2, 32'h22, 1'b0, 32'd0);
    do_wb(3'd0, 32'h11, 1'b0, 32'd0);
    cyc();
    rs_addr_i = {5'd0, 5'd5};
    #1;
    chk("haz_cv_idx0_retiring", 64'(commit_valid_o), 64'b01);
    chk("haz_vec", 64'(hazard_o), 64'b01);
    chk("haz_idx_rs1", 64'(hazard_idx_o[2:0]), 64'd2);
    chk("haz_comp_rs1", 64'(completed_o[0]), 64'd1);
    chk("haz_res_rs1", 64'(result_o[31:0]), 64'h22);
    cyc();
    rs_addr_i = {5'd7, 5'd5};
    #1;
    chk("haz_vec2", 64'(hazard_o), 64'b11);
    chk("haz_idx_rs2", 64'(hazard_idx_o[5:3]), 64'd1);
    chk("haz_comp_rs2", 64'(completed_o[1]), 64'd0);

    // ---------------- writeback bypass into lookup ----------------
    do_reset();
    for (int i = 0; i < 3; i++) do_alloc(32'h500 + 32'(4 * i), 5'(i + 1), 1'b1);
    do_alloc(32'h50C, 5'd9, 1'b1);
    cyc();
    wb_valid_i = 1'b1; wb_idx_i = 3'd3; wb_result_i = 32'hDEAD;
    rs_addr_i = {5'd0, 5'd9};
    #1;
    chk("byp_haz", 64'(hazard_o[0]), 64'd1);
    chk("byp_idx", 64'(hazard_idx_o[2:0]), 64'd3);
    chk("byp_comp_same", 64'(completed_o[0]), 64'(exp_byp));
    if (exp_byp) chk("byp_res_same", 64'(result_o[31:0]), 64'hDEAD);
    cyc();
    rs_addr_i = {5'd0, 5'd9};
    #1;
    chk("byp_comp_next", 64'(completed_o[0]), 64'd1);
    chk("byp_res_next", 64'(result_o[31:0]), 64'hDEAD);

    // ---------------- randomized run against queue model ----------------
    do_reset();
    mq.delete();
    m_head = 0;
    m_tail = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      alloc_valid_i = ($urandom_range(0, 9) < 6);
      alloc_pc_i    = $urandom;
      alloc_instr_i = $urandom;
      alloc_rd_i    = 5'($urandom_range(0, 7));
      alloc_we_i    = ($urandom_range(0, 3) != 0);
      pend.delete();
      foreach (mq[k]) if (!mq[k].done) pend.push_back(mq[k].idx);
      if ($urandom_range(0, 9) < 7) begin
        wb_valid_i = 1'b1;
        if (pend.size() > 0 && $urandom_range(0, 7) != 0)
          wb_idx_i = 3'(pend[$urandom_range(0, pend.size() - 1)]);
        else
          wb_idx_i = 3'($urandom_range(0, 7));
        wb_result_i       = $urandom;
        wb_branch_taken_i = ($urandom_range(0, 9) == 0);
        wb_new_pc_i       = $urandom;
      end
      rs_addr_i = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;

      // Expected commit behaviour from the in-order queue.
      ncm = 0; fl = 1'b0; fpc = 32'd0;
      if (mq.size() > 0 && mq[0].done) begin
        ncm = 1;
        if (mq[0].bt) begin
          fl = 1'b1; fpc = mq[0].npc;
        end else if (mq.size() > 1 && mq[1].done) begin
          ncm = 2;
          if (mq[1].bt) begin fl = 1'b1; fpc = mq[1].npc; end
        end
      end
      chk("rnd_count", 64'(count_o), 64'(mq.size()));
      chk("rnd_ready", 64'(alloc_ready_o), 64'(mq.size() < DEPTH));
      chk("rnd_idx", 64'(alloc_idx_o), 64'(m_tail));
      chk("rnd_cv", 64'(commit_valid_o), (ncm == 2) ? 64'b11 : (ncm == 1) ? 64'b01 : 64'b00);
      chk("rnd_flush", {flush_o, flush_pc_o}, {fl, fpc});
      for (int l = 0; l < ncm; l++) begin
        chk($sformatf("rnd_l%0d_pc", l), 64'(commit_pc_o[l*32 +: 32]), 64'(mq[l].pc));
        chk($sformatf("rnd_l%0d_instr", l), 64'(commit_instr_o[l*32 +: 32]), 64'(mq[l].instr));
        chk($sformatf("rnd_l%0d_rd", l), 64'(commit_rd_o[l*5 +: 5]), 64'(mq[l].rd));
        chk($sformatf("rnd_l%0d_res", l), 64'(commit_result_o[l*32 +: 32]), 64'(mq[l].result));
        chk($sformatf("rnd_l%0d_we", l), 64'(commit_we_o[l]), 64'(mq[l].we && mq[l].rd != 5'd0));
      end
      for (int s = 0; s < 2; s++) begin
        a = rs_addr_i[s*5 +: 5];
        found = -1;
        for (int k = mq.size() - 1; k >= 0; k--) begin
          if (found < 0 && mq[k].we && mq[k].rd == a && a != 5'd0) found = k;
        end
        chk($sformatf("rnd_haz%0d", s), 64'(hazard_o[s]), 64'(found >= 0));
        if (found >= 0) begin
          ecomp = mq[found].done;
          eres  = mq[found].result;
          if (exp_byp && wb_valid_i && int'(wb_idx_i) == mq[found].idx) begin
            ecomp = 1'b1;
            eres  = wb_result_i;
          end
          chk($sformatf("rnd_hidx%0d", s), 64'(hazard_idx_o[s*3 +: 3]), 64'(mq[found].idx));
          chk($sformatf("rnd_comp%0d", s), 64'(completed_o[s]), 64'(ecomp));
          if (ecomp) chk($sformatf("rnd_res%0d", s), 64'(result_o[s*32 +: 32]), 64'(eres));
        end
      end

      // Advance the model to the state after the coming clock edge.
      presize = mq.size();
      if (wb_valid_i && !fl) begin
        foreach (mq[k]) begin
          if (mq[k].idx == int'(wb_idx_i)) begin
            mq[k].done   = 1'b1;
            mq[k].result = wb_result_i;
            mq[k].bt     = wb_branch_taken_i;
            mq[k].npc    = wb_new_pc_i;
          end
        end
      end
      for (int l = 0; l < ncm; l++) void'(mq.pop_front());
      m_head = (m_head + ncm) % DEPTH;
      if (fl) begin
        mq.delete();
        m_tail = m_head;
      end else if (alloc_valid_i && presize < DEPTH) begin
        e.idx = m_tail; e.pc = alloc_pc_i; e.instr = alloc_instr_i; e.rd = alloc_rd_i;
        e.we = alloc_we_i; e.done = 1'b0; e.result = 32'd0; e.bt = 1'b0; e.npc = 32'd0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
